// File: rtl/sample_lag_generator_if.sv
// rtl/sample_lag_generator_if.sv - sample/lag signal bundle between stimulus source and lag generator
interface sample_lag_generator_if #(
  parameter int AW = 8
);
  logic          enable;
  logic [12:0]   sampling_cycle;
  logic [AW-1:0] lag_samples;
  logic [15:0]   sig16b_in;
  logic [15:0]   sig16b;
  logic [15:0]   sig16b_lag;
  logic [12:0]   sampling_cycle_counter;
  logic          sample_valid;
  logic          lag_valid;

  modport master (
    output enable, sampling_cycle, lag_samples, sig16b_in,
    input  sig16b, sig16b_lag, sampling_cycle_counter, sample_valid, lag_valid
  );

  modport slave (
    input  enable, sampling_cycle, lag_samples, sig16b_in,
    output sig16b, sig16b_lag, sampling_cycle_counter, sample_valid, lag_valid
  );
endinterface

// File: rtl/sample_lag_generator.sv
// rtl/sample_lag_generator.sv - periodic sampler with a programmable-lag delay line
module sample_lag_generator #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input logic                   clk_operation,
  input logic                   rst,
  sample_lag_generator_if.slave bus
);
  logic [15:0]   mem [DEPTH];
  logic [12:0]   counter;
  logic [15:0]   sig_q;
  logic [15:0]   lag_q;
  logic          valid_q;
  logic          lag_valid_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] fill_count;
  logic [AW-1:0] lag_registered;
  logic [AW-1:0] rd_addr;
  logic [12:0]   count_max;
  logic          wrap;
  logic          capture;
  logic          lag_changed;
  logic          lag_ready;

  // >= rather than == so a shrinking period wraps immediately instead of running out 13 bits
  always_comb begin
    count_max   = (bus.sampling_cycle <= 13'd1) ? 13'd0 : bus.sampling_cycle - 13'd1;
    wrap        = (counter >= count_max);
    capture     = bus.enable && wrap;
    lag_changed = (bus.lag_samples != lag_registered);
    lag_ready   = !lag_changed && (fill_count >= bus.lag_samples);
    rd_addr     = wr_ptr - bus.lag_samples;
  end

  always_ff @(posedge clk_operation or posedge rst) begin
    if (rst) begin
      counter        <= '0;
      sig_q          <= '0;
      lag_q          <= '0;
      valid_q        <= 1'b0;
      lag_valid_q    <= 1'b0;
      wr_ptr         <= '0;
      fill_count     <= '0;
      lag_registered <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.enable) begin
        counter <= wrap ? 13'd0 : counter + 13'd1;
      end
      if (capture) begin
        sig_q          <= bus.sig16b_in;
        wr_ptr         <= wr_ptr + 1'b1;
        valid_q        <= 1'b1;
        lag_valid_q    <= lag_ready;
        lag_registered <= bus.lag_samples;
        // entries older than the current fill are never trusted, so stale memory reads as 0
        if (bus.lag_samples == '0) begin
          lag_q <= bus.sig16b_in;
        end else if (lag_ready) begin
          lag_q <= mem[rd_addr];
        end else begin
          lag_q <= '0;
        end
        if (lag_changed) begin
          fill_count <= AW'(1);
        end else if (fill_count != AW'(DEPTH - 1)) begin
          fill_count <= fill_count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_operation) begin
    if (capture) begin
      mem[wr_ptr] <= bus.sig16b_in;
    end
  end

  assign bus.sig16b                 = sig_q;
  assign bus.sig16b_lag             = lag_q;
  assign bus.sampling_cycle_counter = counter;
  assign bus.sample_valid           = valid_q;
  assign bus.lag_valid              = lag_valid_q;
endmodule

// File: tb/tb_sample_lag_generator.sv
// tb/tb_sample_lag_generator.sv - scoreboard bench for sample_lag_generator
module tb_sample_lag_generator;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk_operation = 1'b0;
  logic rst = 1'b0;
  always #5 clk_operation = ~clk_operation;

  sample_lag_generator_if #(.AW(AW)) bus ();

  sample_lag_generator #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_operation (clk_operation),
    .rst           (rst),
    .bus           (bus)
  );

  typedef struct {
    logic [15:0] cur;
    logic [15:0] lagv;
    logic        lv;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] hist[$];
  int          run_len;
  int          m_cnt;
  int          m_max;
  bit          m_valid;
  logic [AW-1:0] prev_lag;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_capture();
    exp_t e;
    bit   changed;
    int   lag;
    lag     = int'(bus.lag_samples);
    changed = (bus.lag_samples != prev_lag);
    if (changed) run_len = 0;
    e.cur = bus.sig16b_in;
    e.lv  = !changed && (run_len >= lag);
    if (lag == 0)  e.lagv = bus.sig16b_in;
    else if (e.lv) e.lagv = hist[hist.size() - lag];
    else           e.lagv = 16'h0;
    sbq.push_back(e);
    hist.push_back(bus.sig16b_in);
    run_len++;
    prev_lag = bus.lag_samples;
  endtask

  // reference model of the sample clock and delay line
  always @(posedge clk_operation or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_valid = 0; run_len = 0; prev_lag = '0;
      hist.delete(); sbq.delete();
    end else begin
      m_valid = 0;
      if (bus.enable) begin
        m_max = (bus.sampling_cycle <= 13'd1) ? 0 : int'(bus.sampling_cycle) - 1;
        if (m_cnt >= m_max) begin
          m_cnt = 0; m_valid = 1;
          model_capture();
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(negedge clk_operation) begin
    exp_t e;
    if (!rst) begin
      check("counter", 32'(bus.sampling_cycle_counter), 32'(m_cnt));
      check("sample_valid", 32'(bus.sample_valid), 32'(m_valid));
      if (bus.sample_valid) begin
        check("valid_at_cnt0", 32'(bus.sampling_cycle_counter), 32'd0);
        if (sbq.size() == 0) begin
          check("sb_empty", 32'd0, 32'd1);
        end else begin
          e = sbq.pop_front();
          check("sb_sig16b", 32'(bus.sig16b), 32'(e.cur));
          check("sb_lag", 32'(bus.sig16b_lag), 32'(e.lagv));
          check("sb_lag_valid", 32'(bus.lag_valid), 32'(e.lv));
        end
      end
    end
  end

  task automatic do_capture(input logic [15:0] val, output int waited);
    bus.sig16b_in = val;
    waited = 0;
    do begin
      @(negedge clk_operation);
      waited++;
    end while (!bus.sample_valid && waited < 100);
    if (!bus.sample_valid) check("cap_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk_operation);
    rst = 1'b1;
    @(negedge clk_operation);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"}, 32'(bus.sampling_cycle_counter), 32'd0);
    check({tag, "_sig"}, 32'(bus.sig16b), 32'd0);
    check({tag, "_lag"}, 32'(bus.sig16b_lag), 32'd0);
    check({tag, "_sv"}, 32'(bus.sample_valid), 32'd0);
    check({tag, "_lv"}, 32'(bus.lag_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] t1_in  [5];
    logic [15:0] t1_lag [5];
    logic        t1_lv  [5];
    int w;
    t1_in  = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    t1_lag = '{16'd0, 16'd0, 16'd0, 16'd10, 16'd20};
    t1_lv  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    bus.enable = 1'b0; bus.sampling_cycle = 13'd5; bus.lag_samples = '0; bus.sig16b_in = '0;
    #1 rst = 1'b1;
    #2 check_all_zero("reset");

    // period of 5, lag of 3
    @(negedge clk_operation);
    rst = 1'b0; bus.lag_samples = 8'd3; bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_capture(t1_in[i], w);
      check("t1_period", 32'(w), 32'd5);
      check("t1_lag", 32'(bus.sig16b_lag), 32'(t1_lag[i]));
      check("t1_lv", 32'(bus.lag_valid), 32'(t1_lv[i]));
    end

    // enable low holds everything
    bus.enable = 1'b0;
    repeat (3) @(negedge clk_operation);
    check("hold_cnt", 32'(bus.sampling_cycle_counter), 32'd0);
    check("hold_sig", 32'(bus.sig16b), 32'd50);
    check("hold_sv", 32'(bus.sample_valid), 32'd0);
    bus.enable = 1'b1;

    // lag 0 bypass from reset
    do_reset();
    bus.lag_samples = 8'd0;
    do_capture(16'h8001, w);
    check("byp_sig", 32'(bus.sig16b), 32'h8001);
    check("byp_lag", 32'(bus.sig16b_lag), 32'h8001);
    check("byp_lv", 32'(bus.lag_valid), 32'd1);

    // lag 255, ramp with pointer wrap, capture every clock
    do_reset();
    bus.sampling_cycle = 13'd1; bus.lag_samples = 8'd255;
    for (int k = 1; k <= 300; k++) begin
      do_capture(16'(k), w);
      if (k == 2) check("sc1_period", 32'(w), 32'd1);
      if (k >= 256) check("wrap_lag", 32'(bus.sig16b_lag), 32'(k - 255));
      if (k == 255 || k == 256) check("wrap_lv", 32'(bus.lag_valid), (k == 256) ? 32'd1 : 32'd0);
    end

    // period shrink below counter+1
    do_reset();
    bus.sampling_cycle = 13'd8;
    repeat (3) @(negedge clk_operation);
    check("shrink_cnt3", 32'(bus.sampling_cycle_counter), 32'd3);
    bus.sampling_cycle = 13'd2;
    @(negedge clk_operation);
    check("shrink_cnt0", 32'(bus.sampling_cycle_counter), 32'd0);
    check("shrink_sv", 32'(bus.sample_valid), 32'd1);

    // async reset mid-period, then lag 2 restart
    do_reset();
    bus.sampling_cycle = 13'd5; bus.lag_samples = 8'd2;
    do_capture(16'h1234, w);
    check("pre_sig", 32'(bus.sig16b), 32'h1234);
    repeat (2) @(negedge clk_operation);
    check("pre_cnt2", 32'(bus.sampling_cycle_counter), 32'd2);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk_operation);
    rst = 1'b0;
    do_capture(16'h0A0A, w);
    check("rst_first_lat", 32'(w), 32'd5);
    check("rst_lag_a", 32'(bus.sig16b_lag), 32'd0);
    do_capture(16'h0B0B, w);
    check("rst_lag_b", 32'(bus.sig16b_lag), 32'd0);
    do_capture(16'h0C0C, w);
    check("rst_lag_c", 32'(bus.sig16b_lag), 32'h0A0A);
    check("rst_lv_c", 32'(bus.lag_valid), 32'd1);

    @(negedge clk_operation);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sample_lag_generator.md
SAMPLE_LAG_GENERATOR -- requirements
Module: sample_lag_generator

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning delay-line length in samples (power of two).
REQ-002 SHALL have parameter AW, default 8, meaning log2(DEPTH), the pointer width.
REQ-003 SHALL have port clk_operation, input, 1, meaning the single operation clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1, meaning run; when low, all state holds.
REQ-006 SHALL have port sampling_cycle, input, 13, meaning clocks per sample period.
REQ-007 SHALL have port lag_samples, input, AW, meaning echo lag in sample periods, 0..DEPTH-1.
REQ-008 SHALL have port sig16b_in, input, 16, meaning raw two's-complement input sample.
REQ-009 SHALL have port sig16b, output, 16, meaning the captured current sample.
REQ-010 SHALL have port sig16b_lag, output, 16, meaning the sample captured lag_samples periods earlier.
REQ-011 SHALL have port sampling_cycle_counter, output, 13, meaning the phase within the sample period.
REQ-012 SHALL have port sample_valid, output, 1, meaning a one-clock pulse when new samples are presented.
REQ-013 SHALL have port lag_valid, output, 1, meaning the delay line holds at least lag_samples captures.

Function
REQ-014 SHALL, while enable=1, increment sampling_cycle_counter each clock and set it to 0 on the clock after it equals max(sampling_cycle,1)-1.
REQ-015 SHALL, when sampling_cycle=0 or 1, hold the counter at 0 and capture on every enabled clock.
REQ-016 SHALL, if sampling_cycle is lowered below counter+1, wrap to 0 on the next enabled clock (no 13-bit overflow run-out).
REQ-017 SHALL capture on the edge where the counter wraps to 0, so that sig16b and sig16b_lag are stable for the whole period starting at counter=0.
REQ-018 SHALL perform the following in that same capture edge: sig16b<=sig16b_in; mem[wr_ptr]<=sig16b_in; wr_ptr<=wr_ptr+1 mod DEPTH; sample_valid<=1.
REQ-019 SHALL, for lag_samples>=1, set sig16b_lag<=mem[(wr_ptr-lag_samples) mod DEPTH], read before the write (read-before-write).
REQ-020 SHALL, for lag_samples=0, set sig16b_lag<=sig16b_in (bypass, identical to sig16b).
REQ-021 SHALL keep fill_count, saturating at DEPTH-1, which increments at each capture.
REQ-022 SHALL set lag_valid=1 when fill_count>=lag_registered, where lag_registered is lag_samples latched at each capture.
REQ-023 SHALL force sig16b_lag to 0 on captures where the addressed entry is not yet written (fill_count<lag_samples), so that uninitialised memory is never output.
REQ-024 SHALL, if lag_samples at a capture differs from lag_registered, clear fill_count to 1 (counting this capture) and clear lag_valid; the delay-line contents are retained.
REQ-025 SHALL deassert sample_valid on every clock after the capture clock; it is never high for two consecutive clocks unless sampling_cycle<=1.
REQ-026 SHALL, when enable=0, hold the counter, pointers, outputs, and fill_count; sample_valid becomes 0; no capture occurs.
REQ-027 SHALL add no latency beyond one clock: the value of sig16b_in at the capture edge appears on sig16b in the following cycle.

Reset
REQ-028 SHALL, on rst=1 and immediately without waiting for a clock, drive sampling_cycle_counter=0, sig16b=0, sig16b_lag=0, sample_valid=0, lag_valid=0, wr_ptr=0, fill_count=0, and lag_registered=0.
REQ-029 SHALL not reset delay-line memory; REQ-023 masking covers stale contents.
REQ-030 SHALL, on reset asserted mid-period, abandon the period; after release the counter restarts from 0 and the first capture occurs after max(sampling_cycle,1) enabled clocks.

Verification
REQ-031 SHALL verify: sampling_cycle=5, enable=1 -> counter sequence 0,1,2,3,4,0; sample_valid high only in cycles where counter=0.
REQ-032 SHALL verify: lag_samples=3, inputs 10,20,30,40,50 at successive captures -> sig16b_lag 0,0,0,10,20; lag_valid rises at the 4th capture.
REQ-033 SHALL verify: lag_samples=0, input 0x8001 -> sig16b=sig16b_lag=0x8001 and lag_valid=1 at the first capture.
REQ-034 SHALL verify: lag_samples=255 with 300 captures of ramp k -> at capture k>=256, sig16b_lag=k-255 (pointer wrap-around).
REQ-035 SHALL verify: counter=3, sampling_cycle changed from 8 to 2 -> counter=0 next clock and a capture occurs.
REQ-036 SHALL verify: rst pulsed asynchronously between clock edges at counter=2 -> all outputs 0 before the next edge; with lag=2 and captures A,B,C after release -> sig16b_lag 0,0,A.
